// File: rtl/sobel_edge_engine_if.sv
// Purpose: pixel-stream bundle between a frame-buffer reader and sobel_edge_engine.
// Latency: none (wires only).
// Backpressure: none; the source paces the stream with iDVAL and the engine always accepts.
// Ports:
//   iDATA/iDVAL/iSOF  input pixel, its valid, and the start-of-frame marker (qualified by iDVAL)
//   iMODE/iTHRESHOLD  output mode (latched per frame) and edge threshold (used live)
//   oDATA/oDVAL/oEDGE processed pixel, its valid, and the edge flag for the same pixel
interface sobel_edge_engine_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 10
);
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic              iSOF;
  logic [1:0]        iMODE;
  logic [OUT_W-1:0]  iTHRESHOLD;
  logic [OUT_W-1:0]  oDATA;
  logic              oDVAL;
  logic              oEDGE;

  // Stream source (frame-buffer side / testbench).
  modport master (
    output iDATA, iDVAL, iSOF, iMODE, iTHRESHOLD,
    input  oDATA, oDVAL, oEDGE
  );

  // Edge engine.
  modport slave (
    input  iDATA, iDVAL, iSOF, iMODE, iTHRESHOLD,
    output oDATA, oDVAL, oEDGE
  );
endinterface

// File: rtl/sobel_edge_engine.sv
// Purpose: streaming 3x3 Sobel edge engine (passthrough / magnitude / threshold / inverted threshold).
// Latency: fixed 3 cycles from an accepted beat to oDVAL (window, gradient, magnitude+select).
// Backpressure: none; gaps in iDVAL freeze the window and reappear as gaps on oDVAL.
// Ports:
//   iCLK  pixel clock
//   iRST  synchronous active-high reset
//   bus   sobel_edge_engine_if.slave: pixel stream in, processed pixel / valid / edge flag out
// The interface must be instantiated with the same DATA_W/OUT_W as this module.
module sobel_edge_engine #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 10,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic iCLK,
  input  logic iRST,
  sobel_edge_engine_if.slave bus
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SUM_W  = DATA_W + 2;               // 1*a + 2*b + 1*c
  localparam int GRAD_W = DATA_W + 3;               // signed difference of two sums
  localparam int MAG_W  = DATA_W + 4;               // |Gx| + |Gy|
  // Saturation compare width: wide enough for both mag and the OUT_W ceiling, plus one spare bit.
  localparam int SAT_W  = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_MAG  = 2'd1;
  localparam logic [1:0] MODE_BIN  = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;

  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Position tracking and mode latch (evaluated for the beat on the bus)
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic [1:0]       mode_q, mode_d;
  logic             accept;
  logic             at_origin;
  logic             border;

  always_comb begin
    accept    = bus.iDVAL;
    // iSOF overrides the counters so a mid-line restart re-aligns the frame.
    col_cur   = bus.iSOF ? '0 : col_q;
    row_cur   = bus.iSOF ? '0 : row_q;
    at_origin = (col_cur == '0) && (row_cur == '0);
    // The origin beat itself already runs in the newly sampled mode.
    mode_d    = at_origin ? bus.iMODE : mode_q;
    // Window is incomplete or straddles a line break.
    border    = (int'(row_cur) < 2) || (int'(col_cur) < 2);

    col_d = col_cur;
    row_d = row_cur;
    if (col_cur == COL_W'(IMG_W - 1)) begin
      col_d = '0;
      if (row_cur == ROW_W'(IMG_H - 1)) begin
        row_d = '0;
      end else begin
        row_d = row_cur + ROW_W'(1);
      end
    end else begin
      col_d = col_cur + COL_W'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_PASS;
    end else if (accept) begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds the previous line, lb2 the one before it.
  // Contents are never cleared; stale data is hidden by the border mask.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic [DATA_W-1:0] tap1, tap2;

  always_comb begin
    tap1 = lb1_q[col_cur];
    tap2 = lb2_q[col_cur];
  end

  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_q[col_cur] <= bus.iDATA;
      lb2_q[col_cur] <= tap1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: 3x3 window, win_q[r][c], r=0 oldest row, c=0 oldest column.
  // Only advances on accepted beats, so iDVAL gaps freeze it.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] win_q [3][3];
  logic              v1_q;
  logic              mask1_q;
  logic [1:0]        mode1_q;

  always_ff @(posedge iCLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= tap2;
      win_q[1][2] <= tap1;
      win_q[2][2] <= bus.iDATA;
      mask1_q     <= border;
      mode1_q     <= mode_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= accept;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: gradients and their absolute values.
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0]         sum_l, sum_r, sum_t, sum_b;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0]        abs_x_d, abs_y_d;
  logic [GRAD_W-1:0]        abs_x_q, abs_y_q;
  logic                     v2_q;
  logic                     mask2_q;
  logic [1:0]               mode2_q;
  logic [DATA_W-1:0]        pix2_q;

  always_comb begin
    sum_l = SUM_W'(win_q[0][0]) + SUM_W'({win_q[1][0], 1'b0}) + SUM_W'(win_q[2][0]);
    sum_r = SUM_W'(win_q[0][2]) + SUM_W'({win_q[1][2], 1'b0}) + SUM_W'(win_q[2][2]);
    sum_t = SUM_W'(win_q[0][0]) + SUM_W'({win_q[0][1], 1'b0}) + SUM_W'(win_q[0][2]);
    sum_b = SUM_W'(win_q[2][0]) + SUM_W'({win_q[2][1], 1'b0}) + SUM_W'(win_q[2][2]);
    gx    = GRAD_W'(sum_r) - GRAD_W'(sum_l);
    gy    = GRAD_W'(sum_b) - GRAD_W'(sum_t);
    // |g| never exceeds 4*(2^DATA_W-1), so the negation cannot overflow.
    abs_x_d = gx[GRAD_W-1] ? -gx : gx;
    abs_y_d = gy[GRAD_W-1] ? -gy : gy;
  end

  always_ff @(posedge iCLK) begin
    abs_x_q <= abs_x_d;
    abs_y_q <= abs_y_d;
    mask2_q <= mask1_q;
    mode2_q <= mode1_q;
    pix2_q  <= win_q[2][2];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: magnitude, border mask, saturation, threshold, output select.
  // iTHRESHOLD is used live here, not latched.
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] mag;
  logic [SAT_W-1:0] mag_ext;
  logic [OUT_W-1:0] mag_sat;
  logic [OUT_W-1:0] pass_pix;
  logic             is_edge;
  logic [OUT_W-1:0] data_d;

  // Passthrough pixel is MSB-aligned into the output width.
  generate
    if (OUT_W >= DATA_W) begin : g_pad
      assign pass_pix = OUT_W'(pix2_q) << (OUT_W - DATA_W);
    end else begin : g_trunc
      assign pass_pix = pix2_q[DATA_W-1 -: OUT_W];
    end
  endgenerate

  always_comb begin
    mag     = mask2_q ? '0 : (MAG_W'(abs_x_q) + MAG_W'(abs_y_q));
    mag_ext = SAT_W'(mag);
    mag_sat = (mag_ext > SAT_W'(OUT_MAX)) ? OUT_MAX : mag_ext[OUT_W-1:0];
    // Strictly greater: a magnitude equal to the threshold is not an edge.
    is_edge = (mag_sat > bus.iTHRESHOLD);

    data_d = pass_pix;
    case (mode2_q)
      MODE_PASS: data_d = pass_pix;
      MODE_MAG:  data_d = mag_sat;
      MODE_BIN:  data_d = is_edge ? OUT_MAX : '0;
      MODE_INV:  data_d = is_edge ? '0 : OUT_MAX;
      default:   data_d = pass_pix;
    endcase
  end

  logic [OUT_W-1:0] data_q;
  logic             dval_q;
  logic             edge_q;

  // Data and edge flag hold their last value while no beat completes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_q <= '0;
      dval_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      dval_q <= v2_q;
      if (v2_q) begin
        data_q <= data_d;
        edge_q <= is_edge;
      end
    end
  end

  assign bus.oDATA = data_q;
  assign bus.oDVAL = dval_q;
  assign bus.oEDGE = edge_q;

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Purpose: directed scoreboard bench for sobel_edge_engine on an 8x4 frame.
// Latency: expectations are queued at issue; a forked monitor pops one per oDVAL pulse.
// Backpressure: none; stimulus inserts iDVAL gaps where a test calls for them.
module tb_sobel_edge_engine;

  localparam int DW = 10;
  localparam int OW = 10;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int NPIX = IW * IH;

  localparam int PAT_RAMP  = 0;
  localparam int PAT_CONST = 1;
  localparam int PAT_STEP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_edge_engine_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  sobel_edge_engine #(
    .DATA_W(DW),
    .OUT_W (OW),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    pulses = 0;
  int    thr_cur = 0;
  string cur_test = "reset";

  function automatic void chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s [%s]: got %0d, expected %0d", name, cur_test, got, want);
    end
  endfunction

  // Input pixel for a given pattern at (row, col).
  function automatic int pix_of(input int pat, input int h, input int r, input int c);
    case (pat)
      PAT_RAMP:  return r * IW + c;
      PAT_CONST: return h;
      default:   return (c >= 4) ? h : 0;
    endcase
  endfunction

  // Hand-derived unclamped |Gx|+|Gy| for each pattern:
  //   ramp: columns step by 1 -> Gx=4*2=8, rows step by 8 -> Gy=4*16=64, total 72
  //   const: 0 everywhere
  //   step of height h at col 4: windows ending at col 4 and col 5 straddle it -> Gx=4h
  // Rows 0-1 and cols 0-1 are masked to 0.
  function automatic int mag_of(input int pat, input int h, input int r, input int c);
    if (r < 2 || c < 2) return 0;
    case (pat)
      PAT_RAMP:  return 72;
      PAT_CONST: return 0;
      default:   return (c == 4 || c == 5) ? 4 * h : 0;
    endcase
  endfunction

  task automatic send_beat(input int pix, input logic sof, input logic [1:0] mode_in,
                           input int mag, input logic [1:0] exp_mode, input bit gap);
    exp_t x;
    int   sat;
    sat = (mag > 1023) ? 1023 : mag;
    x.e = (sat > thr_cur);
    case (exp_mode)
      2'd0:    x.d = pix[OW-1:0];
      2'd1:    x.d = sat[OW-1:0];
      2'd2:    x.d = x.e ? 10'd1023 : 10'd0;
      default: x.d = x.e ? 10'd0 : 10'd1023;
    endcase
    sb.push_back(x);
    bus.iDATA = pix[DW-1:0];
    bus.iSOF  = sof;
    bus.iMODE = mode_in;
    bus.iDVAL = 1'b1;
    @(posedge clk);
    #1;
    bus.iDVAL = 1'b0;
    bus.iSOF  = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int pat, input int h, input logic sof,
                            input logic [1:0] m_first, input logic [1:0] m_later,
                            input int change_at, input logic [1:0] exp_mode, input bit gap);
    for (int i = 0; i < NPIX; i++) begin
      send_beat(pix_of(pat, h, i / IW, i % IW), sof && (i == 0),
                (i >= change_at) ? m_later : m_first,
                mag_of(pat, h, i / IW, i % IW), exp_mode, gap);
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Threshold feeds stage 3 live, so let in-flight beats finish first.
  task automatic set_thr(input int t);
    drain();
    thr_cur = t;
    bus.iTHRESHOLD = t[OW-1:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.iDATA      = '0;
    bus.iDVAL      = 1'b0;
    bus.iSOF       = 1'b0;
    bus.iMODE      = 2'd0;
    bus.iTHRESHOLD = '0;

    // Monitor: one expectation consumed per oDVAL pulse, sampled on the falling edge.
    fork
      forever begin
        exp_t x;
        @(negedge clk);
        if (bus.oDVAL === 1'b1) begin
          pulses++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dval [%s]: got oDVAL=1 data=%0d, expected no output",
                     cur_test, bus.oDATA);
          end else begin
            x = sb.pop_front();
            chk("odata", int'(bus.oDATA), int'(x.d));
            chk("oedge", int'(bus.oEDGE), int'(x.e));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_odval", int'(bus.oDVAL), 0);
    chk("reset_odata", int'(bus.oDATA), 0);
    chk("reset_oedge", int'(bus.oEDGE), 0);
    rst = 1'b0;

    cur_test = "pass_ramp_thr71";
    set_thr(71);
    send_frame(PAT_RAMP, 0, 1'b1, 2'd0, 2'd0, NPIX, 2'd0, 1'b0);

    cur_test = "pass_ramp_thr72_equal";
    set_thr(72);
    send_frame(PAT_RAMP, 0, 1'b1, 2'd0, 2'd0, NPIX, 2'd0, 1'b0);

    cur_test = "mag_const500";
    set_thr(0);
    send_frame(PAT_CONST, 500, 1'b1, 2'd1, 2'd1, NPIX, 2'd1, 1'b0);

    cur_test = "mag_step1023_sat";
    set_thr(500);
    send_frame(PAT_STEP, 1023, 1'b1, 2'd1, 2'd1, NPIX, 2'd1, 1'b0);

    cur_test = "bin_step40";
    set_thr(200);
    send_frame(PAT_STEP, 40, 1'b1, 2'd2, 2'd2, NPIX, 2'd2, 1'b0);
    cur_test = "bin_step60";
    send_frame(PAT_STEP, 60, 1'b1, 2'd2, 2'd2, NPIX, 2'd2, 1'b0);
    cur_test = "inv_step60";
    send_frame(PAT_STEP, 60, 1'b1, 2'd3, 2'd3, NPIX, 2'd3, 1'b0);

    // Mode flips 1->2 at beat 13; frame keeps mode 1, next frame (entered by wrap) uses 2.
    cur_test = "mode_change_frameA";
    send_frame(PAT_STEP, 60, 1'b1, 2'd1, 2'd2, 13, 2'd1, 1'b0);
    cur_test = "mode_change_frameB_wrap";
    send_frame(PAT_STEP, 60, 1'b0, 2'd2, 2'd2, NPIX, 2'd2, 1'b0);

    // Five beats of a new frame, then iSOF at col 5 restarts in mode 3.
    cur_test = "partial_then_midline_sof";
    for (int i = 0; i < 5; i++) begin
      send_beat(900, 1'b0, 2'd1, 0, 2'd1, 1'b0);
    end
    send_frame(PAT_STEP, 60, 1'b1, 2'd3, 2'd3, NPIX, 2'd3, 1'b0);

    // iDVAL 1-0-1-0 for ten beats, reset in place of the tenth gap.
    cur_test = "gaps_reset";
    drain();
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      send_beat(pix_of(PAT_STEP, 60, i / IW, i % IW), i == 0, 2'd1,
                mag_of(PAT_STEP, 60, i / IW, i % IW), 2'd1, i < 9);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("inflight_at_reset", sb.size(), 1);
    sb.delete();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pulses_before_reset", pulses - p0, 9);

    // Counters restart at row 0 col 0 and the first beat latches mode 1 (masked -> 0).
    cur_test = "post_reset_frame";
    send_frame(PAT_STEP, 60, 1'b0, 2'd1, 2'd1, NPIX, 2'd1, 1'b1);

    drain();
    cur_test = "end";
    chk("leftover_expectations", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_engine.md
Name: sobel_edge_engine

Overview:
- Parametrised streaming 3x3 edge-detection engine for the camera display path.
- Sits between the frame-buffer read stream and the VGA controller, in the VGA pixel clock domain.
- Generalises the fixed Sobel filter in four ways: configurable pixel width and image geometry, frame-aligned mode selection, border masking, and an output valid/edge flag.

Parameters:
- DATA_W, 10, input pixel width (unsigned).
- OUT_W, 10, output pixel and threshold width.
- IMG_W, 640, pixels per line; sets line-buffer depth.
- IMG_H, 480, lines per frame.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  synchronous reset, active-high.
- iDATA  in  DATA_W  input pixel (luma or green).
- iDVAL  in  1  input pixel valid; one pixel accepted per cycle when high.
- iSOF  in  1  start of frame; qualified by iDVAL, marks the pixel at row 0, col 0.
- iMODE  in  2  0 passthrough, 1 magnitude, 2 binary threshold, 3 inverted binary.
- iTHRESHOLD  in  OUT_W  edge threshold.
- oDATA  out  OUT_W  processed pixel.
- oDVAL  out  1  output valid.
- oEDGE  out  1  magnitude > threshold, for the same pixel as oDATA.

Behaviour:
- Reset:
  - oDATA=0, oDVAL=0, oEDGE=0.
  - Column and row counters = 0; mode register = 0.
  - Pipeline valid bits cleared.
  - Line-buffer RAM contents are not cleared; border masking hides stale data.
- Acceptance and stalls:
  - A beat is accepted only when iDVAL=1. Line buffers, 3x3 window and counters advance only on accepted beats.
  - Gaps in iDVAL freeze the window and produce matching gaps on oDVAL.
- Window:
  - Two IMG_W-deep line buffers plus 3x3 shift registers.
  - Bottom-right tap = current pixel; other rows come from 1 and 2 lines back.
- Counters:
  - col counts 0..IMG_W-1 and wraps to 0, incrementing row.
  - row counts 0..IMG_H-1 and wraps to 0.
  - An accepted beat with iSOF=1 is forced to col=0, row=0, overriding the counters; counting continues from there.
- Mode latching:
  - iMODE is sampled only on the accepted beat at col=0, row=0, whether reached via iSOF or via wrap.
  - It holds for the whole frame; mid-frame changes take effect at the next frame.
- Arithmetic, with p[r][c], r=0 the oldest row and c=0 the oldest column:
  - Gx = (p02 + 2·p12 + p22) - (p00 + 2·p10 + p20), signed, DATA_W+3 bits.
  - Gy = (p20 + 2·p21 + p22) - (p00 + 2·p01 + p02), same width.
  - mag = |Gx| + |Gy|, unsigned, DATA_W+4 bits.
  - mag_sat = min(mag, 2^OUT_W - 1).
- Border mask: when the accepted beat has row<2 or col<2, mag is forced to 0 (window incomplete or straddles a line).
- Output select, per mode:
  - 0: oDATA = input pixel, MSB-aligned to OUT_W (truncated or zero-padded).
  - 1: oDATA = mag_sat.
  - 2: oDATA = all ones if mag_sat > iTHRESHOLD, else 0.
  - 3: oDATA = 0 if mag_sat > iTHRESHOLD, else all ones.
- oEDGE = (mag_sat > iTHRESHOLD) in every mode; it is 0 on masked pixels. Equality is not an edge.
- iTHRESHOLD is sampled in the pipeline stage that performs the compare; no latching.
- Latency:
  - Fixed 3 cycles from accepted beat to oDVAL=1, in all modes (window register, gradient, magnitude/select).
  - Output is not spatially re-centred: it corresponds to the window whose bottom-right is that beat.
- oDVAL is high exactly one cycle per accepted beat. oDATA and oEDGE hold their last value while oDVAL=0.
- Reset mid-frame:
  - In-flight beats are dropped; no oDVAL pulses for them.
  - The next accepted beat is treated as row 0, col 0 and border-masked.
- iSOF mid-line: counters restart and the window is treated as a new frame; the following 2 rows are masked.

Test Plan (IMG_W=8, IMG_H=4, DATA_W=OUT_W=10):
- Reset, mode 0, stream ramp 0..31 with iSOF on the first pixel -> oDVAL 3 cycles after each beat; oDATA = input values, identical sequence.
- Mode 1, constant frame of 500 -> every oDATA = 0 and oEDGE = 0, including the border positions.
- Mode 1, vertical step (cols 0-3 = 0, cols 4-7 = 1023) -> at row≥2, col 4 and col 5 the unclamped mag = 4092; oDATA saturates to 1023. Positions with row<2 or col<2 output 0.
- Mode 2, threshold 200, step height 40 (mag 160 at the step) -> oDATA = 0, oEDGE = 0. Step height 60 (mag 240) -> oDATA = 1023, oEDGE = 1. Mode 3 on the same data -> oDATA inverted.
- Change iMODE 1→2 at mid-frame beat 13 -> output stays in mode 1 until the next row 0, col 0 beat, then switches.
- iDVAL toggling 1-0-1-0 plus an iRST pulse at beat 10 -> oDVAL pulse count equals the number of accepted beats minus those in flight at reset. The first post-reset beat outputs 0 in mode 1.
